// File: rtl/life_generation_scheduler.sv
// Paces Game-of-Life generation steps against VGA frame timing and flips the
// double-buffered arena bank only on a frame boundary.
module life_generation_scheduler #(
    parameter int VSYNC_POSITIVE = 1,
    parameter int DIV_WIDTH      = 6,
    parameter int GEN_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 run_enable,
    input  logic                 single_step,
    input  logic [DIV_WIDTH-1:0] frame_period,
    input  logic                 step_done,
    output logic                 step_req,
    output logic                 display_bank,
    output logic                 write_bank,
    output logic                 swap_pulse,
    output logic [GEN_WIDTH-1:0] generation,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_FRAMES = 2'd1,
        STEP        = 2'd2,
        SWAP_WAIT   = 2'd3
    } state_t;

    localparam logic ACTIVE_HIGH = (VSYNC_POSITIVE != 0);

    state_t               state;
    logic                 vs_act;
    logic                 vs_prev;
    logic                 frame_tick;
    logic [DIV_WIDTH-1:0] frame_count;
    logic [DIV_WIDTH-1:0] period_eff;
    logic [DIV_WIDTH:0]   count_next;

    // History resets to "active" so a vsync held active through reset is not a tick.
    assign vs_act     = ACTIVE_HIGH ? vsync : ~vsync;
    assign frame_tick = vs_act & ~vs_prev;

    assign period_eff = (frame_period == '0) ? DIV_WIDTH'(1) : frame_period;
    assign count_next = {1'b0, frame_count} + (DIV_WIDTH + 1)'(1);

    assign write_bank = ~display_bank;

    // Engine handshake: step_req rises on entry to STEP and holds until the
    // cycle after step_done is sampled; step_done is honoured only in STEP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            step_req     <= 1'b0;
            busy         <= 1'b0;
            display_bank <= 1'b0;
            swap_pulse   <= 1'b0;
            generation   <= '0;
            frame_count  <= '0;
            vs_prev      <= 1'b1;
        end else begin
            vs_prev    <= vs_act;
            swap_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_enable) begin
                        state       <= WAIT_FRAMES;
                        frame_count <= '0;
                        busy        <= 1'b1;
                    end else if (single_step) begin
                        state    <= STEP;
                        step_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT_FRAMES: begin
                    if (!run_enable) begin
                        state       <= IDLE;
                        frame_count <= '0;
                        busy        <= 1'b0;
                    end else if (frame_tick) begin
                        if (count_next >= {1'b0, period_eff}) begin
                            state       <= STEP;
                            step_req    <= 1'b1;
                            frame_count <= '0;
                        end else begin
                            frame_count <= count_next[DIV_WIDTH-1:0];
                        end
                    end
                end
                STEP: begin
                    if (step_done) begin
                        state    <= SWAP_WAIT;
                        step_req <= 1'b0;
                    end
                end
                SWAP_WAIT: begin
                    // The swap frame itself counts as frame 0 of the next period.
                    if (frame_tick) begin
                        display_bank <= ~display_bank;
                        generation   <= generation + GEN_WIDTH'(1);
                        swap_pulse   <= 1'b1;
                        frame_count  <= '0;
                        if (run_enable) begin
                            state <= WAIT_FRAMES;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    step_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
